// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 I/O responder: register addresses, STAT layout
// and the UART transmitter state encoding.
package j1_io_pkg;

    localparam logic [15:0] ADDR_DATA = 16'h1000;
    localparam logic [15:0] ADDR_STAT = 16'h2000;
    localparam logic [15:0] ADDR_GPIO = 16'h4000;
    localparam logic [15:0] ADDR_TLO  = 16'h8000;
    localparam logic [15:0] ADDR_THI  = 16'h8001;

    localparam int STAT_TX_NOT_FULL = 0;
    localparam int STAT_RX_FULL     = 1;
    localparam int STAT_TX_OVF      = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [15:0] stat_word(input logic tx_ovf,
                                              input logic rx_full,
                                              input logic tx_not_full);
        logic [15:0] w;
        w = '0;
        w[STAT_TX_OVF]      = tx_ovf;
        w[STAT_RX_FULL]     = rx_full;
        w[STAT_TX_NOT_FULL] = tx_not_full;
        return w;
    endfunction

endpackage

// File: rtl/j1_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser. Frames run back to back
// while the FIFO holds data; the serialiser state is exposed on 'state'.
module j1_uart_tx
    import j1_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 48,
    parameter int TX_DEPTH     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] data,
    input  logic       overflow_clr,
    output logic       full,
    output logic       overflow,
    output logic       uart_tx,
    output tx_state_t  state
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [7:0]    mem [TX_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          empty;
    logic          bit_end;
    logic          pop;
    logic          do_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bit_end = (state != TX_IDLE) && (baud_cnt == BAUD_LAST);
    assign pop     = !empty && ((state == TX_IDLE) || ((state == TX_STOP) && bit_end));
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            overflow <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A dropped push in the same cycle as a clear leaves the flag set.
            if (overflow_clr) begin
                overflow <= 1'b0;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end

            if ((state == TX_IDLE) || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            case (state)
                TX_IDLE: begin
                    if (pop) begin
                        state   <= TX_START;
                        shift   <= mem[rd_ptr[AW-1:0]];
                        uart_tx <= 1'b0;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        state   <= TX_DATA;
                        bit_idx <= '0;
                        uart_tx <= shift[0];
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state   <= TX_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            uart_tx <= shift[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state   <= TX_START;
                            shift   <= mem[rd_ptr[AW-1:0]];
                            uart_tx <= 1'b0;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/j1_io_port.sv
// J1 I/O bus responder: decodes io_rd/io_wr cycles into UART TX, RX holding
// register, GPIO latch and a 32-bit tick counter with a coherent high-half shadow.
module j1_io_port
    import j1_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 48,
    parameter int TX_DEPTH     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] io_din,
    output logic        uart_tx,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  gpio
);

    logic [31:0] ticks;
    logic [15:0] ticks_hi_shadow;
    logic [7:0]  rx_byte;
    logic        rx_full;
    logic        tx_full;
    logic        tx_overflow;
    logic [15:0] rd_data;
    logic        tx_push;
    logic        tx_ovf_clr;
    tx_state_t   tx_state_unused;
    logic [7:0]  dout_hi_unused;

    assign tx_push        = io_wr && (mem_addr == ADDR_DATA);
    assign tx_ovf_clr     = io_wr && (mem_addr == ADDR_STAT);
    assign dout_hi_unused = dout[15:8];

    j1_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .TX_DEPTH    (TX_DEPTH)
    ) u_tx (
        .clk         (clk),
        .reset       (reset),
        .push        (tx_push),
        .data        (dout[7:0]),
        .overflow_clr(tx_ovf_clr),
        .full        (tx_full),
        .overflow    (tx_overflow),
        .uart_tx     (uart_tx),
        .state       (tx_state_unused)
    );

    // Read mux sees only registered state, so a same-cycle write never leaks in.
    always_comb begin
        rd_data = '0;
        case (mem_addr)
            ADDR_DATA: rd_data = rx_full ? {8'h00, rx_byte} : 16'h0000;
            ADDR_STAT: rd_data = stat_word(tx_overflow, rx_full, !tx_full);
            ADDR_GPIO: rd_data = {8'h00, gpio};
            ADDR_TLO:  rd_data = ticks[15:0];
            ADDR_THI:  rd_data = ticks_hi_shadow;
            default:   rd_data = '0;
        endcase
    end

    // RX handshake: a byte transfers on any cycle with rx_valid && rx_ready;
    // rx_ready then stays low until the core reads DATA, freeing the slot next cycle.
    assign rx_ready = !rx_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            io_din          <= '0;
            gpio            <= '0;
            rx_byte         <= '0;
            rx_full         <= 1'b0;
            ticks           <= '0;
            ticks_hi_shadow <= '0;
        end else begin
            ticks <= ticks + 32'd1;
            if (io_rd) begin
                io_din <= rd_data;
            end
            if (io_rd && (mem_addr == ADDR_TLO)) begin
                ticks_hi_shadow <= ticks[31:16];
            end
            if (io_wr && (mem_addr == ADDR_GPIO)) begin
                gpio <= dout[7:0];
            end
            if (io_rd && (mem_addr == ADDR_DATA)) begin
                rx_full <= 1'b0;
            end
            if (rx_valid && rx_ready) begin
                rx_byte <= rx_data;
                rx_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_j1_io_port.sv
// Bench for j1_io_port: register-level model of the I/O map plus a line decoder
// that turns the uart_tx waveform back into bytes.
module tb_j1_io_port;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam logic [15:0] A_DATA = 16'h1000;
    localparam logic [15:0] A_STAT = 16'h2000;
    localparam logic [15:0] A_GPIO = 16'h4000;
    localparam logic [15:0] A_TLO  = 16'h8000;
    localparam logic [15:0] A_THI  = 16'h8001;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] io_din;
    logic        uart_tx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  gpio;

    int checks = 0;
    int errors = 0;

    // Scoreboard and reference model state.
    logic [7:0] exp_q[$];
    logic [7:0] burst_q[$];
    logic [8:0] got_q[$];
    int         gap_q[$];
    bit         mon_en;
    logic       m_full;
    logic [7:0] m_byte;
    logic       m_ovf;
    logic [7:0] m_gpio;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    j1_io_port #(
        .CLKS_PER_BIT(CPB),
        .TX_DEPTH    (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .mem_addr(mem_addr),
        .dout    (dout),
        .io_din  (io_din),
        .uart_tx (uart_tx),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .gpio    (gpio)
    );

    // ---------------- line decoder ----------------
    // Each frame is 10 slots of CPB samples; every sample in a slot must agree.
    initial begin : line_mon
        int         idle;
        int         gap;
        bit         ok;
        bit         abort;
        logic       v;
        logic [9:0] slot;
        idle = 0;
        v    = 1'b1;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) begin
                idle = 0;
            end else if (uart_tx !== 1'b0) begin
                idle++;
            end else begin
                gap   = idle;
                ok    = 1'b1;
                abort = 1'b0;
                slot  = '0;
                for (int s = 0; s < 10; s++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (s != 0 || c != 0) @(negedge clk);
                        if (!mon_en || reset) abort = 1'b1;
                        if (c == 0) v = uart_tx;
                        else if (uart_tx !== v) ok = 1'b0;
                    end
                    slot[s] = v;
                end
                if (!abort) begin
                    got_q.push_back({ok && !slot[0] && slot[9], slot[8:1]});
                    gap_q.push_back(gap);
                end
                idle = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        io_wr = 1'b1; mem_addr = a; dout = d;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        io_rd = 1'b1; mem_addr = a;
        @(negedge clk);
        io_rd = 1'b0;
        d = io_din;
    endtask

    task automatic push_burst(input int n);
        logic [7:0] b;
        burst_q.delete();
        @(negedge clk);
        io_wr = 1'b1; mem_addr = A_DATA;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            burst_q.push_back(b);
            dout = {8'($urandom), b};
            @(negedge clk);
        end
        io_wr = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b;
        if (!m_full) begin
            m_full = 1'b1;
            m_byte = b;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (got_q.size() >= n);
    endtask

    function automatic logic [15:0] exp_stat(input logic ovf, input logic rxf, input logic txnf);
        return {13'h0, ovf, rxf, txnf};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        m_full = 1'b0; m_ovf = 1'b0; m_gpio = 8'h00;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx got %b exp 1", uart_tx); end
        checks++; if (gpio !== 8'h00) begin errors++; $display("FAIL reset_gpio got %h exp 00", gpio); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b exp 1", rx_ready); end
        checks++; if (io_din !== 16'h0000) begin errors++; $display("FAIL reset_io_din got %h exp 0000", io_din); end
        reset = 1'b0;
        io_read(A_STAT, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL reset_stat got %h exp 0001", d); end
    endtask

    task automatic test_tx_pattern();
        bit          ok;
        logic [7:0]  b;
        logic [15:0] d;
        got_q.delete(); gap_q.delete(); exp_q.delete();
        mon_en = 1'b1;
        exp_q.push_back(8'h55);
        io_write(A_DATA, 16'hAB55);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_idle_before_pop got %b exp 1", uart_tx); end
        @(negedge clk);
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL tx_start_latency got %b exp 0", uart_tx); end
        for (int i = 0; i < 4; i++) begin
            wait_frames(i + 1, 12 * CPB, ok);
            b = 8'($urandom);
            exp_q.push_back(b);
            io_write(A_DATA, {8'($urandom), b});
        end
        wait_frames(5, 12 * CPB, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL tx_frames_timeout got %0d exp 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[i] !== {1'b1, exp_q[i]}) begin
                    errors++; $display("FAIL tx_frame%0d got %h exp %h", i, got_q[i], {1'b1, exp_q[i]});
                end
            end
        end
        io_read(A_STAT, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL tx_stat_idle got %h exp 0001", d); end
    endtask

    task automatic test_back_to_back(input int n);
        bit          ok;
        int          acc;
        logic [15:0] d;
        got_q.delete(); gap_q.delete(); exp_q.delete();
        mon_en = 1'b1;
        push_burst(n);
        // One byte leaves the FIFO for the serialiser at once; DEPTH more fit behind it.
        acc = (n < DEPTH + 1) ? n : DEPTH + 1;
        for (int i = 0; i < acc; i++) exp_q.push_back(burst_q[i]);
        m_ovf = (n > DEPTH + 1);
        io_read(A_STAT, d);
        checks++;
        if (d !== exp_stat(m_ovf, 1'b0, (acc - 1) < DEPTH)) begin
            errors++; $display("FAIL b2b_stat n=%0d got %h exp %h", n, d, exp_stat(m_ovf, 1'b0, (acc - 1) < DEPTH));
        end
        io_write(A_STAT, 16'($urandom));
        m_ovf = 1'b0;
        io_read(A_STAT, d);
        checks++;
        if (d !== exp_stat(1'b0, 1'b0, (acc - 1) < DEPTH)) begin
            errors++; $display("FAIL b2b_stat_clr got %h exp %h", d, exp_stat(1'b0, 1'b0, (acc - 1) < DEPTH));
        end
        wait_frames(acc, (acc + 2) * 10 * CPB, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_timeout got %0d exp %0d", got_q.size(), acc);
        end else begin
            for (int i = 0; i < acc; i++) begin
                checks++;
                if (got_q[i] !== {1'b1, exp_q[i]}) begin
                    errors++; $display("FAIL b2b_frame%0d got %h exp %h", i, got_q[i], {1'b1, exp_q[i]});
                end
                if (i > 0) begin
                    checks++;
                    if (gap_q[i] !== 0) begin errors++; $display("FAIL b2b_gap%0d got %0d exp 0", i, gap_q[i]); end
                end
            end
        end
        repeat (20 * CPB) @(negedge clk);
        checks++; if (got_q.size() !== acc) begin errors++; $display("FAIL b2b_frame_count got %0d exp %0d", got_q.size(), acc); end
        io_read(A_STAT, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL b2b_stat_drained got %h exp 0001", d); end
    endtask

    task automatic test_rx();
        logic [15:0] d;
        logic [7:0]  b;
        rx_send(8'hA7);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_full got %b exp 0", rx_ready); end
        io_read(A_STAT, d);
        checks++; if (d !== exp_stat(m_ovf, m_full, 1'b1)) begin errors++; $display("FAIL rx_stat got %h exp %h", d, exp_stat(m_ovf, m_full, 1'b1)); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                b = 8'($urandom);
                rx_send(b);
                rx_send(~b);
            end
            io_read(A_DATA, d);
            checks++;
            if (d !== (m_full ? {8'h00, m_byte} : 16'h0000)) begin
                errors++; $display("FAIL rx_data%0d got %h exp %h", i, d, m_full ? {8'h00, m_byte} : 16'h0000);
            end
            m_full = 1'b0;
            checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_freed%0d got %b exp 1", i, rx_ready); end
        end
        io_read(A_DATA, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rx_read_empty got %h exp 0000", d); end
    endtask

    task automatic test_gpio();
        logic [15:0] d;
        logic [15:0] a;
        logic [15:0] w;
        for (int i = 0; i < 5; i++) begin
            w = (i == 0) ? 16'h1234 : 16'($urandom);
            io_write(A_GPIO, w);
            m_gpio = w[7:0];
            checks++; if (gpio !== m_gpio) begin errors++; $display("FAIL gpio_pin%0d got %h exp %h", i, gpio, m_gpio); end
            io_read(A_GPIO, d);
            checks++; if (d !== {8'h00, m_gpio}) begin errors++; $display("FAIL gpio_read%0d got %h exp %h", i, d, {8'h00, m_gpio}); end
        end
        repeat (3) @(negedge clk);
        checks++; if (io_din !== {8'h00, m_gpio}) begin errors++; $display("FAIL io_din_hold got %h exp %h", io_din, {8'h00, m_gpio}); end
        for (int i = 0; i < 5; i++) begin
            a = (i == 0) ? 16'h0300 : 16'($urandom);
            while (a == A_DATA || a == A_STAT || a == A_GPIO || a == A_TLO || a == A_THI) a = 16'($urandom);
            io_write(a, 16'($urandom));
            io_read(a, d);
            checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_read %h got %h exp 0000", a, d); end
            checks++; if (gpio !== m_gpio) begin errors++; $display("FAIL unmapped_write %h gpio got %h exp %h", a, gpio, m_gpio); end
        end
    endtask

    task automatic test_rd_wr_same_cycle();
        logic [7:0] nv;
        logic [7:0] b;
        bit         ok;
        nv = 8'($urandom);
        if (nv == m_gpio) nv = ~m_gpio;
        @(negedge clk);
        io_rd = 1'b1; io_wr = 1'b1; mem_addr = A_GPIO; dout = {8'($urandom), nv};
        @(negedge clk);
        io_rd = 1'b0; io_wr = 1'b0;
        checks++; if (io_din !== {8'h00, m_gpio}) begin errors++; $display("FAIL rdwr_gpio_old got %h exp %h", io_din, {8'h00, m_gpio}); end
        m_gpio = nv;
        checks++; if (gpio !== m_gpio) begin errors++; $display("FAIL rdwr_gpio_new got %h exp %h", gpio, m_gpio); end
        got_q.delete(); gap_q.delete();
        mon_en = 1'b1;
        rx_send(8'($urandom));
        b = 8'($urandom);
        @(negedge clk);
        io_rd = 1'b1; io_wr = 1'b1; mem_addr = A_DATA; dout = {8'h00, b};
        @(negedge clk);
        io_rd = 1'b0; io_wr = 1'b0;
        checks++; if (io_din !== {8'h00, m_byte}) begin errors++; $display("FAIL rdwr_data_read got %h exp %h", io_din, {8'h00, m_byte}); end
        m_full = 1'b0;
        wait_frames(1, 12 * CPB, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rdwr_tx_timeout got %0d exp 1", got_q.size());
        end else if (got_q[0] !== {1'b1, b}) begin
            errors++; $display("FAIL rdwr_tx_frame got %h exp %h", got_q[0], {1'b1, b});
        end
    endtask

    task automatic test_ticks();
        logic [15:0] t0;
        logic [15:0] t1;
        logic [15:0] d;
        int          gap;
        gap = $urandom_range(1, 40);
        io_read(A_TLO, t0);
        repeat (gap) @(negedge clk);
        io_read(A_TLO, t1);
        checks++; if (16'(t1 - t0) !== 16'(gap + 2)) begin errors++; $display("FAIL ticks_delta got %0d exp %0d", 16'(t1 - t0), gap + 2); end
        @(negedge clk);
        io_rd = 1'b1; mem_addr = A_TLO;
        force dut.ticks = 32'h0001_FFFF;
        #1 release dut.ticks;
        @(negedge clk);
        io_rd = 1'b0;
        checks++; if (io_din !== 16'hFFFF) begin errors++; $display("FAIL ticks_tlo got %h exp ffff", io_din); end
        repeat (3) @(negedge clk);
        io_read(A_THI, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL ticks_thi_shadow got %h exp 0001", d); end
        io_read(A_TLO, d);
        checks++; if (d !== 16'h0006) begin errors++; $display("FAIL ticks_tlo_wrapped got %h exp 0006", d); end
        io_read(A_THI, d);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL ticks_thi_carry got %h exp 0002", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        int          lows;
        mon_en = 1'b0;
        push_burst(3);
        repeat (CPB / 2) @(negedge clk);
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_active got %b exp 0", uart_tx); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx got %b exp 1", uart_tx); end
        checks++; if (gpio !== 8'h00) begin errors++; $display("FAIL midframe_reset_gpio got %h exp 00", gpio); end
        reset = 1'b0;
        m_full = 1'b0; m_ovf = 1'b0; m_gpio = 8'h00;
        io_read(A_STAT, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL midframe_stat got %h exp 0001", d); end
        lows = 0;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL midframe_line_idle got %0d low samples exp 0", lows); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; mem_addr = '0; dout = '0;
        rx_valid = 1'b0; rx_data = '0; mon_en = 1'b0;
        m_full = 1'b0; m_byte = '0; m_ovf = 1'b0; m_gpio = '0;
        test_reset();
        test_tx_pattern();
        test_back_to_back(DEPTH + 2);
        test_back_to_back($urandom_range(2, DEPTH + 4));
        test_rx();
        test_gpio();
        test_rd_wr_same_cycle();
        test_ticks();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
